// File: rtl/io_defs.sv
// io_defs: shared definitions for the memory-mapped IO controller.
//   - timer FSM state encoding
//   - register addresses (TIMER_LOAD, TIMER_COUNT, STATUS)
//   - RAM size and data width
//   - ram_idx(): byte index helper with modulo-RAM_BYTES wrap
// Optional feature macro used by io_timer: IO_AUTO_RELOAD_EN.
package io_defs;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned RAM_BYTES = 2048;
   localparam int unsigned RAM_AW    = 11;

   localparam logic [11:0] ADDR_TIMER_LOAD  = 12'hFF0;
   localparam logic [11:0] ADDR_TIMER_COUNT = 12'hFF4;
   localparam logic [11:0] ADDR_STATUS      = 12'hFF8;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCount   = 2'd1,
      StReq     = 2'd2,
      StAckWait = 2'd3
   } timer_state_t;

   // Byte index of a word lane; the RAM address space wraps, so 0x7FF+1 -> 0x000.
   function automatic logic [RAM_AW-1:0] ram_idx(input logic [RAM_AW-1:0] base,
                                                input logic [1:0]        off);
      return base + {{(RAM_AW-2){1'b0}}, off};
   endfunction

endpackage

// File: rtl/io_timer.sv
// io_timer: down-counting interrupt timer with request/acknowledge handshake.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   load_we       - write strobe for the TIMER_LOAD register
//   load_data     - value written to TIMER_LOAD
//   intr_ack      - interrupt acknowledge from the CPU
//   count         - live counter value
//   reload        - stored TIMER_LOAD value
//   intr_req      - registered interrupt request
//   st_count      - FSM is in COUNT
//   st_ack_wait   - FSM is in ACK_WAIT
// Macro IO_AUTO_RELOAD_EN: when defined, leaving ACK_WAIT restarts the count from
// reload (periodic); otherwise the timer returns to IDLE (one-shot).
module io_timer
   import io_defs::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_we,
   input  logic [DATA_W-1:0] load_data,
   input  logic              intr_ack,
   output logic [DATA_W-1:0] count,
   output logic [DATA_W-1:0] reload,
   output logic              intr_req,
   output logic              st_count,
   output logic              st_ack_wait
);

   timer_state_t      state_q, state_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] reload_q, reload_d;
   logic              irq_q, irq_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         reload_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      irq_d    = irq_q;

      if (load_we) begin
         // A load overrides whatever the FSM was doing, including a pending request.
         reload_d = load_data;
         count_d  = load_data;
         irq_d    = 1'b0;
         state_d  = (load_data != '0) ? StCount : StIdle;
      end else begin
         case (state_q)
            StIdle: begin
            end
            StCount: begin
               if (count_q <= 1) begin
                  count_d = '0;
                  irq_d   = 1'b1;
                  state_d = StReq;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
            StReq: begin
               if (intr_ack) begin
                  irq_d   = 1'b0;
                  state_d = StAckWait;
               end
            end
            StAckWait: begin
               // Wait for the ack to drop so a held ack cannot swallow the next request.
               if (!intr_ack) begin
`ifdef IO_AUTO_RELOAD_EN
                  count_d = reload_q;
                  state_d = StCount;
`else
                  count_d = '0;
                  state_d = StIdle;
`endif
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign count       = count_q;
   assign reload      = reload_q;
   assign intr_req    = irq_q;
   assign st_count    = (state_q == StCount);
   assign st_ack_wait = (state_q == StAckWait);

endmodule

// File: rtl/io_controller.sv
// io_controller: CPU-side IO block with a 2048-byte big-endian RAM and a timer.
// Map: 0x000-0x7FF RAM, 0xFF0 TIMER_LOAD (R/W), 0xFF4 TIMER_COUNT (R),
//      0xFF8 STATUS (R) = {29'b0, ack_wait, intr_req, counting}; others read 0.
// Ports:
//   sys_clk  - system clock, rising edge
//   reset    - asynchronous active-high reset (RAM contents are kept)
//   Address  - 12-bit byte address
//   D_in     - 32-bit write data
//   IO_wr    - write strobe, commits at the clock edge
//   IO_rd    - read strobe, D_out is combinational while high, 0 otherwise
//   D_out    - 32-bit read data
//   intr_req - registered interrupt request
//   intr_ack - interrupt acknowledge
// Macro IO_AUTO_RELOAD_EN selects a periodic timer (see io_timer).
module io_controller
   import io_defs::*;
(
   input  logic              sys_clk,
   input  logic              reset,
   input  logic [11:0]       Address,
   input  logic [DATA_W-1:0] D_in,
   input  logic              IO_wr,
   input  logic              IO_rd,
   output logic [DATA_W-1:0] D_out,
   output logic              intr_req,
   input  logic              intr_ack
);

   logic [7:0]        mem [RAM_BYTES];
   logic              in_ram;
   logic              ram_we;
   logic              load_we;
   logic [RAM_AW-1:0] base;
   logic [RAM_AW-1:0] idx0, idx1, idx2, idx3;
   logic [DATA_W-1:0] tmr_count;
   logic [DATA_W-1:0] tmr_reload;
   logic              st_count;
   logic              st_ack_wait;

   assign in_ram  = ~Address[11];
   assign base    = Address[RAM_AW-1:0];
   assign ram_we  = IO_wr & in_ram;
   assign load_we = IO_wr & (Address == ADDR_TIMER_LOAD);

   assign idx0 = ram_idx(base, 2'd0);
   assign idx1 = ram_idx(base, 2'd1);
   assign idx2 = ram_idx(base, 2'd2);
   assign idx3 = ram_idx(base, 2'd3);

   // No reset on the RAM: contents survive a reset.
   always_ff @(posedge sys_clk) begin
      if (ram_we) begin
         mem[idx0] <= D_in[31:24];
         mem[idx1] <= D_in[23:16];
         mem[idx2] <= D_in[15:8];
         mem[idx3] <= D_in[7:0];
      end
   end

   io_timer u_timer (
      .clk         (sys_clk),
      .rst         (reset),
      .load_we     (load_we),
      .load_data   (D_in),
      .intr_ack    (intr_ack),
      .count       (tmr_count),
      .reload      (tmr_reload),
      .intr_req    (intr_req),
      .st_count    (st_count),
      .st_ack_wait (st_ack_wait)
   );

   // Combinational read sees pre-edge state, so a read+write cycle returns old data.
   always_comb begin
      D_out = '0;
      if (IO_rd) begin
         if (in_ram) begin
            D_out = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
         end else if (Address == ADDR_TIMER_LOAD) begin
            D_out = tmr_reload;
         end else if (Address == ADDR_TIMER_COUNT) begin
            D_out = tmr_count;
         end else if (Address == ADDR_STATUS) begin
            D_out = {29'b0, st_ack_wait, intr_req, st_count};
         end
      end
   end

endmodule
